// File: rtl/fe_fetch_stage_pkg.sv
// Shared types and constants for the fetch stage and its neighbours.
package fe_fetch_stage_pkg;

  localparam int          FE_DBITS    = 32;
  localparam int          FE_INSTSIZE = 4;
  localparam int          FE_BHR_BITS = 8;
  localparam logic [31:0] FE_RESET_PC = 32'h0000_0000;

  // Interface bus widths between FE and its neighbours.
  localparam int FE_TO_DE_WIDTH = 1 + (3 * FE_DBITS) + FE_BHR_BITS;
  localparam int DE_TO_FE_WIDTH = 1;
  localparam int FE_TO_BP_WIDTH = FE_DBITS;
  localparam int BP_TO_FE_WIDTH = 1 + FE_DBITS + FE_BHR_BITS;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fe_state_e;

  // Sequential (fall-through) successor of a fetch PC; wraps modulo 2^DBITS.
  function automatic logic [FE_DBITS-1:0] next_seq_pc(input logic [FE_DBITS-1:0] pc);
    return pc + FE_INSTSIZE[FE_DBITS-1:0];
  endfunction

endpackage

// File: rtl/fe_skid_buffer.sv
// Skid register for the instruction word. While DE stalls, imem_rdata moves
// on, so the word that was on the bus when the stall began is kept here and
// steered to DE instead of the live memory output.
module fe_skid_buffer #(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             sel,
  input  logic [DBITS-1:0] rdata,
  output logic [DBITS-1:0] inst
);

  logic             sv_r;
  logic [DBITS-1:0] sinst_r;

  // Capture the live word on load; clear wins so a flush or resume always drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sv_r    <= 1'b0;
      sinst_r <= '0;
    end else if (clear) begin
      sv_r    <= 1'b0;
      sinst_r <= sinst_r;
    end else if (load) begin
      sv_r    <= 1'b1;
      sinst_r <= rdata;
    end else begin
      sv_r    <= sv_r;
      sinst_r <= sinst_r;
    end
  end

  // Present the held word only when asked for and actually holding one.
  always_comb begin
    inst = rdata;
    if (sel && sv_r) begin
      inst = sinst_r;
    end else begin
      inst = rdata;
    end
  end

endmodule

// File: rtl/fe_fetch_stage.sv
// Fetch stage: owns the fetch PC, follows the branch predictor's next-PC or
// redirect, drives a synchronous-read instruction memory and hands
// {valid, inst, PC, predicted PC, BHR} to decode, holding it across stalls.
module fe_fetch_stage
  import fe_fetch_stage_pkg::*;
#(
  parameter int               DBITS    = FE_DBITS,
  parameter int               BHR_BITS = FE_BHR_BITS,
  parameter logic [DBITS-1:0] RESET_PC = FE_RESET_PC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DBITS+BHR_BITS:0]       from_BP_to_FE,
  input  logic                          from_DE_to_FE,
  output logic [DBITS-1:0]              imem_addr,
  input  logic [DBITS-1:0]              imem_rdata,
  output logic [DBITS-1:0]              from_FE_to_BP,
  output logic [3*DBITS+BHR_BITS:0]     from_FE_to_DE
);

  // Predictor / decode inputs
  logic                flush_s;
  logic [DBITS-1:0]    new_pc_s;
  logic [BHR_BITS-1:0] bhr_in_s;
  logic                stall_s;

  // Architectural fetch PC and F1 latch
  logic [DBITS-1:0]    pc_r;
  logic                v1_r;
  logic [DBITS-1:0]    pc1_r;
  logic [DBITS-1:0]    pred1_r;
  logic [BHR_BITS-1:0] bhr1_r;
  fe_state_e           state_r;

  // Next-state controls
  fe_state_e           state_nxt_s;
  logic [DBITS-1:0]    pc_nxt_s;
  logic                v1_nxt_s;
  logic                f1_load_s;
  logic                skid_load_s;
  logic                skid_clear_s;
  logic                skid_sel_s;
  logic [DBITS-1:0]    inst_s;

  assign flush_s  = from_BP_to_FE[DBITS+BHR_BITS];
  assign new_pc_s = from_BP_to_FE[DBITS+BHR_BITS-1 -: DBITS];
  assign bhr_in_s = from_BP_to_FE[BHR_BITS-1:0];
  assign stall_s  = from_DE_to_FE;

  assign imem_addr     = pc_r;
  assign from_FE_to_BP = pc_r;
  assign skid_sel_s    = (state_r == ST_STALL);

  // Sequencing: BOOT only primes the memory with pc_r (nothing committed, so
  // the next cycle is a second bubble); RUN/STALL advance when DE accepts;
  // a flush beats everything and restarts through BOOT.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    v1_nxt_s     = v1_r;
    f1_load_s    = 1'b0;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (flush_s) begin
      pc_nxt_s     = new_pc_s;
      v1_nxt_s     = 1'b0;
      skid_clear_s = 1'b1;
      state_nxt_s  = ST_BOOT;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          if (!stall_s) begin
            pc_nxt_s  = new_pc_s;
            v1_nxt_s  = 1'b1;
            f1_load_s = 1'b1;
          end else if (v1_r) begin
            skid_load_s = 1'b1;
            state_nxt_s = ST_STALL;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_STALL: begin
          if (!stall_s) begin
            pc_nxt_s     = new_pc_s;
            v1_nxt_s     = 1'b1;
            f1_load_s    = 1'b1;
            skid_clear_s = 1'b1;
            state_nxt_s  = ST_RUN;
          end else begin
            state_nxt_s = ST_STALL;
          end
        end
        default: begin
          v1_nxt_s     = 1'b0;
          skid_clear_s = 1'b1;
          state_nxt_s  = ST_BOOT;
        end
      endcase
    end
  end

  // State, fetch PC and F1 latch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_PC;
      v1_r    <= 1'b0;
      pc1_r   <= '0;
      pred1_r <= '0;
      bhr1_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      v1_r    <= v1_nxt_s;
      if (f1_load_s) begin
        pc1_r   <= pc_r;
        pred1_r <= new_pc_s;
        bhr1_r  <= bhr_in_s;
      end else begin
        pc1_r   <= pc1_r;
        pred1_r <= pred1_r;
        bhr1_r  <= bhr1_r;
      end
    end
  end

  fe_skid_buffer #(
    .DBITS (DBITS)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load_s),
    .clear (skid_clear_s),
    .sel   (skid_sel_s),
    .rdata (imem_rdata),
    .inst  (inst_s)
  );

  assign from_FE_to_DE = {v1_r, inst_s, pc1_r, pred1_r, bhr1_r};

endmodule

// File: tb/tb_fe_fetch_stage.sv
// Bench for fe_fetch_stage: acts as predictor, decode and instruction memory,
// and checks every cycle against a transaction-level fetch model.
module tb_fe_fetch_stage;
  import fe_fetch_stage_pkg::*;

  logic         clk;
  logic         reset;
  logic [40:0]  from_BP_to_FE;
  logic         from_DE_to_FE;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic [31:0]  from_FE_to_BP;
  logic [104:0] from_FE_to_DE;

  int n_cmp;
  int n_err;

  // Model: expected fetch PC, expected DE entry, and "next edge is a priming edge".
  logic [31:0] m_pc;
  logic        m_v;
  logic [31:0] m_opc;
  logic [31:0] m_opred;
  logic [7:0]  m_obhr;
  logic        m_prime;

  fe_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .from_BP_to_FE (from_BP_to_FE),
    .from_DE_to_FE (from_DE_to_FE),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .from_FE_to_BP (from_FE_to_BP),
    .from_FE_to_DE (from_FE_to_DE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[15:0], a[31:16]} ^ 32'hC0DE_1234) + a;
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("imem_addr", {32'd0, imem_addr}, {32'd0, m_pc});
    check("fe_to_bp", {32'd0, from_FE_to_BP}, {32'd0, m_pc});
    check("de_valid", {63'd0, from_FE_to_DE[104]}, {63'd0, m_v});
    if (m_v) begin
      check("de_inst", {32'd0, from_FE_to_DE[103:72]}, {32'd0, mem_word(m_opc)});
      check("de_pc", {32'd0, from_FE_to_DE[71:40]}, {32'd0, m_opc});
      check("de_pred", {32'd0, from_FE_to_DE[39:8]}, {32'd0, m_opred});
      check("de_bhr", {56'd0, from_FE_to_DE[7:0]}, {56'd0, m_obhr});
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_0000;
    m_v     = 1'b0;
    m_prime = 1'b1;
  endtask

  // One clock: drive inputs, check at negedge, advance model at posedge.
  task automatic cyc(input logic fl, input logic [31:0] npc, input logic st);
    logic [7:0] b;
    b = 8'($urandom);
    from_BP_to_FE = {fl, npc, b};
    from_DE_to_FE = st;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (fl) begin
      m_pc    = npc;
      m_v     = 1'b0;
      m_prime = 1'b1;
    end else if (m_prime) begin
      m_prime = 1'b0;
    end else if (!st) begin
      m_v     = 1'b1;
      m_opc   = m_pc;
      m_opred = npc;
      m_obhr  = b;
      m_pc    = npc;
    end
    #1;
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, next_seq_pc(m_pc), 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_opc = 32'd0; m_opred = 32'd0; m_obhr = 8'd0;
    reset = 1'b1;
    from_BP_to_FE = 41'd0;
    from_DE_to_FE = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;

    // 1: sequential fetch after reset
    seq(5);
    // 2: taken prediction at 0x10 -> 0x40
    check("pc_before_taken", {32'd0, from_FE_to_BP}, 64'h10);
    cyc(1'b0, 32'h0000_0040, 1'b0);
    check("taken_addr", {32'd0, imem_addr}, 64'h40);
    seq(2);

    // 3: stall three cycles with PC 0x8 at DE
    cyc(1'b1, 32'h0000_0008, 1'b0);
    seq(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, next_seq_pc(m_pc), 1'b1);
    check("stall_pc", {32'd0, from_FE_to_DE[71:40]}, 64'h8);
    check("stall_inst", {32'd0, from_FE_to_DE[103:72]}, {32'd0, mem_word(32'h8)});
    check("stall_addr", {32'd0, imem_addr}, 64'hC);
    seq(3);

    // 4: flush to 0x100 while stalled
    cyc(1'b0, next_seq_pc(m_pc), 1'b1);
    cyc(1'b0, next_seq_pc(m_pc), 1'b1);
    cyc(1'b1, 32'h0000_0100, 1'b1);
    check("flush_addr", {32'd0, imem_addr}, 64'h100);
    seq(4);

    // 5: asynchronous reset mid-cycle while stalled
    seq(2);
    cyc(1'b0, next_seq_pc(m_pc), 1'b1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_valid", {63'd0, from_FE_to_DE[104]}, 64'd0);
    check("async_pc", {32'd0, from_FE_to_BP}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seq(4);

    // 6: wrap from 0xFFFF_FFFC to 0
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
    seq(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        fl;
      logic        st;
      logic [31:0] npc;
      fl  = ($urandom_range(19) == 0);
      st  = ($urandom_range(3) == 0);
      npc = ($urandom_range(4) == 0) ? ($urandom() & 32'hFFFF_FFFC) : next_seq_pc(m_pc);
      cyc(fl, npc, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
